uart_num_sender: RTL
====================

// Module: uart_num_sender
// PURPOSE
//  Reverse path of the UART number link: takes a 6-digit packed-BCD value and transmits it as ASCII text.
//  Drives the byte-strobe interface of tx_uart (tx_data + 1-cycle tx_ready), pacing bytes itself.
//  Sits between the value source (ctrl/display path, 24-bit BCD) and tx_uart, beside rx_uart/ctrl_uart.
//  Output per request: optional leading-zero-suppressed digits, then optional CR LF.
// PARAMETERS
//  CLK_FREQ      50_000_000  system clock, Hz
//  BAUD          115200      line rate, matches tx_uart
//  GAP_CYCLES    (CLK_FREQ/BAUD)*11  cycles between tx_ready pulses (1 frame + 1 bit guard); 4774 at defaults
//  SUPPRESS_LZ   1           1: drop leading '0' digits (all-zero value still sends one '0')
//  APPEND_CRLF   1           1: append 0x0D 0x0A after the digits
// PORTS
//  clk       in   1   system clock, rising edge
//  rst       in   1   asynchronous active-low reset
//  start     in   1   request; sampled only in IDLE
//  bcd_in    in   24  6 BCD nibbles, [23:20] most significant digit; latched on accepted start
//  tx_data   out  8   byte for tx_uart; valid whenever tx_ready=1, held until next byte
//  tx_ready  out  1   1-cycle strobe: tx_uart starts sending tx_data
//  busy      out  1   1 from cycle after accepted start through done cycle inclusive
//  done      out  1   1-cycle pulse: message complete, block back to IDLE next cycle
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, tx_data=8'h00, tx_ready=0, busy=0, done=0, counters/index 0.
//  Reset mid-message: abort immediately, no further strobes; a byte already handed to tx_uart is not recalled.
//  FSM: IDLE -> SEND -> GAP -> (SEND | FIN) ; FIN -> IDLE.
//   IDLE: start=1 at edge k -> latch bcd_in, idx=first digit index, go SEND; start=0 -> stay.
//   SEND (1 cycle): tx_ready=1, tx_data=byte[idx]; load gap counter with GAP_CYCLES-1; go GAP.
//   GAP: count down; at 0 -> idx+1 if more bytes go SEND, else go FIN.
//   FIN (1 cycle): done=1; go IDLE.
//  Timing: first tx_ready at cycle k+1; successive tx_ready exactly GAP_CYCLES cycles apart;
//   done exactly GAP_CYCLES cycles after last tx_ready; new start accepted earliest the cycle after done.
//  Byte list: digit i -> 8'h30+nibble for nibble 0..9; nibble 10..15 -> 8'h3F ('?'); then 0x0D,0x0A if APPEND_CRLF.
//  First digit index (SUPPRESS_LZ=1): most significant nibble !=0, computed from bcd_in at latch time;
//   all six nibbles 0 -> index 5 (single '0'). Non-BCD nibble counts as nonzero. SUPPRESS_LZ=0 -> index 0.
//  Message length 1..8 bytes; idx width 3 bits, never wraps within a message.
//  start while busy: ignored, not queued. start held high: one message per IDLE visit (re-triggers after done).
//  bcd_in changes after latch: no effect on current message.
//  tx_data/tx_ready are registered outputs; no combinational path from inputs to outputs.
// STRUCTURE
//  Shared header uart_defs.vh: ASCII_0 8'h30, ASCII_QM 8'h3F, ASCII_CR 8'h0D, ASCII_LF 8'h0A, FSM state encodings.
//  One sub-module: uart_gap_timer (load/count/expire pulse, width $clog2(GAP_CYCLES)); digit->ASCII as a function.
// TESTING  (bench overrides GAP_CYCLES=8, CLK 10 ns)
//  1 bcd_in=24'h001234, start pulse -> strobes '1','2','3','4',CR,LF = 31 32 33 34 0D 0A, 8 cycles apart, then done.
//  2 bcd_in=24'h000000 -> single 30 0D 0A; SUPPRESS_LZ=0 with 24'h000042 -> 30 30 30 30 34 32 0D 0A.
//  3 bcd_in=24'h1A0F09 -> 31 3F 30 3F 30 39 0D 0A; busy high throughout, done once.
//  4 start re-pulsed during GAP and bcd_in changed mid-message -> ignored; bytes match latched value.
//  5 rst=0 asserted during 3rd GAP -> tx_ready/busy/done 0 same cycle, no further strobes; next start sends full message.
//  6 start held high across two messages -> second message's first strobe 1 cycle after IDLE re-entry; tx-echo loop to rx_uart decodes text.

Source files
------------

// File: rtl/uart_num_sender_pkg.sv
// Shared definitions for the UART number sender: FSM states, ASCII codes and
// the digit/byte helpers used to build the outgoing text.
package uart_num_sender_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_QM = 8'h3F;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Byte index 0..5 are digits (0 = most significant), 6 = CR, 7 = LF.
  localparam logic [2:0] IDX_LAST_DIGIT = 3'd5;
  localparam logic [2:0] IDX_CR         = 3'd6;
  localparam logic [2:0] IDX_LF         = 3'd7;

  function automatic logic [7:0] digit_to_ascii(input logic [3:0] nib);
    if (nib <= 4'd9) begin
      return ASCII_0 + {4'h0, nib};
    end
    return ASCII_QM;
  endfunction

  function automatic logic [3:0] digit_at(input logic [23:0] bcd, input logic [2:0] idx);
    logic [3:0] nib;
    case (idx)
      3'd0:    nib = bcd[23:20];
      3'd1:    nib = bcd[19:16];
      3'd2:    nib = bcd[15:12];
      3'd3:    nib = bcd[11:8];
      3'd4:    nib = bcd[7:4];
      3'd5:    nib = bcd[3:0];
      default: nib = 4'h0;
    endcase
    return nib;
  endfunction

  // Non-BCD nibbles count as significant; an all-zero value keeps the last digit.
  function automatic logic [2:0] first_digit_idx(input logic [23:0] bcd, input logic suppress);
    logic [2:0] idx;
    idx = suppress ? IDX_LAST_DIGIT : 3'd0;
    if (suppress) begin
      for (int i = 5; i >= 0; i--) begin
        if (digit_at(bcd, 3'(i)) != 4'h0) begin
          idx = 3'(i);
        end
      end
    end
    return idx;
  endfunction

  function automatic logic [7:0] byte_at(input logic [23:0] bcd, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      IDX_CR:  b = ASCII_CR;
      IDX_LF:  b = ASCII_LF;
      default: b = digit_to_ascii(digit_at(bcd, idx));
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_num_sender_if.sv
// Request/byte-strobe bundle between the value source, the number sender and tx_uart.
interface uart_num_sender_if;

  logic        start;
  logic [23:0] bcd_in;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        busy;
  logic        done;

  modport master (
    output start, bcd_in,
    input  tx_data, tx_ready, busy, done
  );

  modport slave (
    input  start, bcd_in,
    output tx_data, tx_ready, busy, done
  );

endinterface

// File: rtl/uart_num_sender_gap_timer.sv
// Down-counter that paces byte strobes: load sets GAP_CYCLES-1, expired_o is
// high once the count has run down to zero.
module uart_num_sender_gap_timer #(
  parameter int GAP_CYCLES = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  output logic expired_o
);

  localparam int CW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(GAP_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/uart_num_sender.sv
// Sends a latched 6-digit BCD value to tx_uart as ASCII text, optionally with
// leading zeros dropped and CR LF appended, one strobe every GAP_CYCLES cycles.
module uart_num_sender #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int GAP_CYCLES  = (CLK_FREQ / BAUD) * 11,
  parameter bit SUPPRESS_LZ = 1'b1,
  parameter bit APPEND_CRLF = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  uart_num_sender_if.slave link
);

  import uart_num_sender_pkg::*;

  localparam logic [2:0] LAST_IDX = APPEND_CRLF ? IDX_LF : IDX_LAST_DIGIT;

  state_e      state_q;
  logic [23:0] bcd_q;
  logic [2:0]  idx_q;
  logic [7:0]  tx_data_q;
  logic        tx_ready_q;
  logic        busy_q;
  logic        done_q;

  logic [2:0]  first_idx_d;
  logic [7:0]  first_byte_d;
  logic [2:0]  next_idx_d;
  logic [7:0]  next_byte_d;
  logic        last_byte;
  logic        timer_load_d;
  logic        gap_expired;

  // The gap timer is reloaded on the same edge that raises each strobe, so
  // strobes land exactly GAP_CYCLES apart.
  always_comb begin
    first_idx_d  = first_digit_idx(link.bcd_in, SUPPRESS_LZ);
    first_byte_d = byte_at(link.bcd_in, first_idx_d);
    next_idx_d   = idx_q + 3'd1;
    next_byte_d  = byte_at(bcd_q, next_idx_d);
    last_byte    = (idx_q == LAST_IDX);
    timer_load_d = ((state_q == ST_IDLE) && link.start) ||
                   ((state_q == ST_GAP) && gap_expired && !last_byte);
  end

  uart_num_sender_gap_timer #(
    .GAP_CYCLES (GAP_CYCLES)
  ) u_gap_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (timer_load_d),
    .expired_o (gap_expired)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      bcd_q      <= '0;
      idx_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_ready_q <= 1'b0;
          done_q     <= 1'b0;
          if (link.start) begin
            bcd_q      <= link.bcd_in;
            idx_q      <= first_idx_d;
            tx_data_q  <= first_byte_d;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ST_SEND;
          end
        end
        ST_SEND: begin
          tx_ready_q <= 1'b0;
          state_q    <= ST_GAP;
        end
        ST_GAP: begin
          if (gap_expired) begin
            if (!last_byte) begin
              idx_q      <= next_idx_d;
              tx_data_q  <= next_byte_d;
              tx_ready_q <= 1'b1;
              state_q    <= ST_SEND;
            end else begin
              done_q  <= 1'b1;
              state_q <= ST_FIN;
            end
          end
        end
        ST_FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign link.tx_data  = tx_data_q;
  assign link.tx_ready = tx_ready_q;
  assign link.busy     = busy_q;
  assign link.done     = done_q;

endmodule
